// File: rtl/seg_afterglow_driver.sv
// Per-segment PWM driver with afterglow: lit segments run at full duty, and dark
// segments fade out one brightness step every DECAY_DIV PWM frames.
module seg_afterglow_driver #(
    parameter int PWM_BITS  = 4,
    parameter int DECAY_DIV = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_enable,
    input  logic [5:0] io_segAtoF,
    output logic [5:0] io_segOut,
    output logic       io_frame
);
    localparam int MAX   = (1 << PWM_BITS) - 1;
    localparam int DIV_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(MAX - 1);
    localparam logic [PWM_BITS-1:0] B_FULL   = PWM_BITS'(MAX);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DECAY_DIV - 1);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [DIV_W-1:0]    div_cnt;
    logic [5:0]          seg_reg;
    logic [PWM_BITS-1:0] b [6];

    logic frame_end;
    logic decay_step;

    // One-step decrement that stops at zero instead of wrapping to full.
    function automatic logic [PWM_BITS-1:0] sat0_dec(input logic [PWM_BITS-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    assign frame_end  = io_enable && (pwm_cnt == PWM_LAST);
    assign decay_step = (div_cnt == DIV_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pwm_cnt   <= '0;
            div_cnt   <= '0;
            seg_reg   <= '0;
            io_segOut <= '0;
            io_frame  <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                b[i] <= '0;
            end
        end else begin
            seg_reg <= io_segAtoF;
            if (io_enable) begin
                for (int i = 0; i < 6; i++) begin
                    io_segOut[i] <= (pwm_cnt < b[i]);
                end
                io_frame <= (pwm_cnt == '0);
                pwm_cnt  <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
                // Brightness only moves at the frame boundary so duty is stable within a frame;
                // a captured lit bit beats a decay step on the same boundary.
                if (frame_end) begin
                    div_cnt <= decay_step ? '0 : div_cnt + 1'b1;
                    for (int i = 0; i < 6; i++) begin
                        b[i] <= seg_reg[i] ? B_FULL : (decay_step ? sat0_dec(b[i]) : b[i]);
                    end
                end
            end else begin
                io_segOut <= '0;
                io_frame  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seg_afterglow_driver.sv
// Bench for seg_afterglow_driver: directed phases plus random stimulus, compared
// every edge against a frame/decay-count model of brightness.
module tb_seg_afterglow_driver;
    localparam int PB  = 4;
    localparam int D   = 4;
    localparam int MAX = (1 << PB) - 1;

    logic       clock;
    logic       reset;
    logic       io_enable;
    logic [5:0] io_segAtoF;
    logic [5:0] io_segOut;
    logic       io_frame;

    seg_afterglow_driver #(.PWM_BITS(PB), .DECAY_DIV(D)) dut (
        .clock      (clock),
        .reset      (reset),
        .io_enable  (io_enable),
        .io_segAtoF (io_segAtoF),
        .io_segOut  (io_segOut),
        .io_frame   (io_frame)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Model: k = enabled edges since reset, nb = frame boundaries seen,
    // last_lit[i] = boundary index where segment i was last captured lit (-1 = never).
    int         k;
    int         nb;
    int         last_lit [6];
    logic [5:0] segreg_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        k = 0;
        nb = 0;
        segreg_m = '0;
        for (int i = 0; i < 6; i++) last_lit[i] = -1;
    endtask

    // Brightness = full minus decay steps (boundaries that are multiples of D) since last lit.
    function automatic int bright(input int i);
        int v;
        if (last_lit[i] < 0) return 0;
        v = MAX - (nb / D - last_lit[i] / D);
        return (v < 0) ? 0 : v;
    endfunction

    task automatic step(input logic en, input logic [5:0] seg);
        logic [5:0] eo;
        logic       ef;
        int         pos;
        io_enable  = en;
        io_segAtoF = seg;
        @(posedge clock);
        eo = '0;
        ef = 1'b0;
        if (en) begin
            pos = k % MAX;
            for (int i = 0; i < 6; i++) eo[i] = (pos < bright(i));
            ef = (pos == 0);
            if (pos == MAX - 1) begin
                nb++;
                for (int i = 0; i < 6; i++) if (segreg_m[i]) last_lit[i] = nb;
            end
            k++;
        end
        segreg_m = seg;
        #1;
        chk("seg_out", {26'd0, io_segOut}, {26'd0, eo});
        chk("frame", {31'd0, io_frame}, {31'd0, ef});
    endtask

    task automatic frame_count(input logic [5:0] seg, output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        repeat (MAX) begin
            step(1'b1, seg);
            c0 += int'(io_segOut[0]);
            c1 += int'(io_segOut[1]);
        end
    endtask

    initial begin
        int         c0, c1, v1, guard, fr;
        logic       en_r;
        logic [5:0] seg_r;

        reset = 1'b0;
        io_enable = 1'b1;
        io_segAtoF = 6'h3F;
        model_reset();
        #1;
        chk("rst_out_t0", {26'd0, io_segOut}, 32'd0);
        chk("rst_frame_t0", {31'd0, io_frame}, 32'd0);
        repeat (3) begin
            @(posedge clock);
            #1;
            chk("rst_out", {26'd0, io_segOut}, 32'd0);
            chk("rst_frame", {31'd0, io_frame}, 32'd0);
        end
        reset = 1'b1;

        step(1'b1, 6'b000001);
        chk("first_frame", {31'd0, io_frame}, 32'd1);

        // Steady on for bits 0 and 1.
        repeat (44) step(1'b1, 6'b000011);
        while (k % MAX != 0) step(1'b1, 6'b000011);
        frame_count(6'b000011, c0, c1);
        chk("steady_b0", c0, MAX);
        chk("steady_b1", c1, MAX);

        // Fade both; retrigger bit 0 at level 7 on a decay-step boundary.
        guard = 0;
        while (!(bright(0) == 7 && k % MAX == MAX - 2 && (nb + 1) % D == 0) && guard < 3000) begin
            step(1'b1, 6'b000000);
            guard++;
        end
        chk("retrig_reach", {31'd0, guard < 3000}, 32'd1);
        v1 = bright(1);
        step(1'b1, 6'b000001);
        step(1'b1, 6'b000000);
        frame_count(6'b000000, c0, c1);
        chk("retrig_b0", c0, MAX);
        chk("retrig_b1", c1, v1 - 1);

        // Pause mid-frame at pwm position 5.
        while (k % MAX != 5) step(1'b1, 6'b000000);
        repeat (20) step(1'b0, 6'b000000);
        fr = 0;
        repeat (MAX - 5) begin
            step(1'b1, 6'b000000);
            fr += int'(io_frame);
        end
        chk("pause_noframe", fr, 0);
        step(1'b1, 6'b000000);
        chk("pause_frame", {31'd0, io_frame}, 32'd1);

        // Random patterns and random enable gaps.
        seg_r = '0;
        repeat (600) begin
            en_r = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) seg_r = 6'($urandom & $urandom);
            step(en_r, seg_r);
        end

        // Full fade to the floor, no wrap.
        repeat (1000) step(1'b1, 6'b000000);
        frame_count(6'b000000, c0, c1);
        chk("floor_b0", c0, 0);
        chk("floor_b1", c1, 0);

        // Async reset in the middle of a fade.
        repeat (20) step(1'b1, 6'b000001);
        guard = 0;
        while (!(bright(0) == 9 && k % MAX == 3) && guard < 3000) begin
            step(1'b1, 6'b000000);
            guard++;
        end
        chk("areset_reach", {31'd0, guard < 3000}, 32'd1);
        chk("areset_pre", {31'd0, io_segOut[0]}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("areset_out", {26'd0, io_segOut}, 32'd0);
        chk("areset_frame", {31'd0, io_frame}, 32'd0);
        io_segAtoF = 6'h00;
        repeat (2) begin
            @(posedge clock);
            #1;
            chk("areset_hold", {26'd0, io_segOut}, 32'd0);
        end
        reset = 1'b1;
        model_reset();
        step(1'b1, 6'b000000);
        chk("areset_first_frame", {31'd0, io_frame}, 32'd1);
        repeat (60) step(1'b1, 6'b000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg_afterglow_driver.md
# seg_afterglow_driver

Downstream stage of the segment animation block. It takes the 6-bit A–F segment pattern and drives the physical segment pins with per-segment PWM brightness. A segment that is lit shows full brightness. A segment that goes dark fades out over a programmable number of PWM frames, which gives a trailing "comet" afterglow on the rotating animation.

## Interface
- `PWM_BITS`, default 4: brightness width. `MAX = 2^PWM_BITS - 1` (15).
- `DECAY_DIV`, default 4: number of PWM frames per one-step brightness decrement. Must be ≥ 1.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-low. 0 = reset.
- `io_enable`  in  1: 1 = run, 0 = freeze.
- `io_segAtoF`  in  6: segment pattern from the animation stage, active-high.
- `io_segOut`  out  6: PWM-modulated segment drive, active-high, registered.
- `io_frame`  out  1: one-cycle pulse at the start of each PWM frame, registered.

## Operation
- State:
  - `pwmCnt` (`PWM_BITS`): counts 0..MAX-1 and wraps, so a frame is MAX cycles (15).
  - `divCnt` (0..`DECAY_DIV`-1): counts frames, free-running.
  - `segReg[5:0]`: input capture register.
  - `b[i]` (`PWM_BITS`, i = 0..5): per-segment brightness.
- `segReg` loads `io_segAtoF` on every edge, regardless of `io_enable`.
- On each edge with `io_enable=1`:
  - `io_segOut[i] <= (pwmCnt < b[i])`, using pre-edge values.
  - `io_frame <= (pwmCnt == 0)`.
  - `pwmCnt` increments, with MAX-1 → 0.
- Frame boundary is the edge with `io_enable=1` and `pwmCnt == MAX-1`. At that edge:
  - `decayStep = (divCnt == DECAY_DIV-1)`.
  - `divCnt` increments and wraps to 0 when `decayStep`.
  - Per segment: `b[i] <= segReg[i] ? MAX : (decayStep ? sat0(b[i]-1) : b[i])`.
- `b` changes only at frame boundaries, so the duty never changes mid-frame.
- Brightness semantics: b = MAX gives the output high for all MAX cycles of the frame; b = 0 gives it always low; b = k gives exactly k high cycles per frame, at frame positions 0..k-1.
- Decrement saturates at 0. There is no underflow wrap.
- An asserted input always wins over decay in the same boundary, which is the retrigger rule.
- `DECAY_DIV = 1`: every frame boundary is a decay step.
- With `io_enable=0`:
  - `pwmCnt`, `divCnt` and `b` hold.
  - `io_segOut <= 0` and `io_frame <= 0` on the next edge.
  - On re-enable, counting resumes from the held `pwmCnt`; no frame restart.

## Timing
- Reset values (asynchronous, immediate on `reset=0`): `pwmCnt=0`, `divCnt=0`, `segReg=0`, `b=0`, `io_segOut=0`, `io_frame=0`.
- First edge after reset release with `io_enable=1`: `io_frame=1`.
- `io_frame` is high for 1 cycle every MAX cycles.
- Input-to-brightness latency: 1 edge into `segReg`, then up to MAX edges to the frame boundary. The new duty is visible on `io_segOut` starting 1 edge after that boundary.
- Full fade from MAX to 0 takes MAX decay steps = MAX·`DECAY_DIV` frames (60 frames, 900 cycles by default).
- The first step lands 1..`DECAY_DIV` frames after release, because `divCnt` is free-running. Subsequent steps are spaced exactly `DECAY_DIV` frames.
- Reset asserted mid-fade clears everything at once. After release, behaviour is identical to power-up.

## Test plan
- **Reset:**
  - Stimulus: hold `reset=0` for 3 cycles with `io_segAtoF=6'h3F`, `io_enable=1`.
  - Required: `io_segOut=0` and `io_frame=0` throughout.
  - Stimulus: release reset.
  - Required: `io_frame` pulses on the 1st edge, then every 15 cycles.
- **Steady on:**
  - Stimulus: `io_segAtoF=6'b000001`, enable=1.
  - Required: after the first boundary, `io_segOut[0]` is high 15/15 cycles per frame; bits 5..1 are 0.
- **Fade:**
  - Stimulus: from steady on, drop `io_segAtoF[0]` to 0.
  - Required: high-count per frame steps 15 → 14 → … → 0. Each level lasts exactly 4 frames, except the first, which lasts 1..4 frames. Bit 0 stays 0 thereafter, with no wrap to 15.
- **Retrigger:**
  - Stimulus: when the high-count reaches 7, pulse `io_segAtoF[0]=1` for 1 cycle.
  - Required: the following frame shows 15 high cycles.
  - Stimulus: on the same boundary as the retrigger, let another fading segment take its decay step.
  - Required: that segment still decrements by exactly 1.
- **Pause:**
  - Stimulus: mid-frame at `pwmCnt=5`, set enable=0 for 20 cycles.
  - Required: `io_segOut=0` and `io_frame=0` from the next edge; `b` unchanged.
  - Stimulus: re-enable.
  - Required: next `io_frame` comes exactly 10 enabled edges later (the remaining positions 5..14 of the frame); duty continues with no extra decay step.
- **Async reset mid-fade:**
  - Stimulus: assert `reset=0` between clock edges at b=9.
  - Required: `io_segOut` goes to 0 immediately without a clock edge.
  - Stimulus: release reset with `io_segAtoF=0`.
  - Required: all outputs stay 0 apart from `io_frame` pulses.
